// File: rtl/shared_adder_arbiter.sv
// shared_adder_arbiter
// One registered WIDTH-bit adder shared by NUM_REQ requesters under
// round-robin arbitration. Results return on a single response channel
// tagged with the id of the requester that supplied the operands.
//
// Handshake (both channels): a transfer happens on a rising clock edge where
// valid && ready are both high. A source holds valid and its payload stable
// until that edge. req_ready depends combinationally on req_valid. rsp_valid
// never depends on rsp_ready.
module shared_adder_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    localparam int IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic                     rsp_carry,
    output logic [IDW-1:0]           rsp_id,
    output logic                     busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        RESP = 2'd2
    } state_t;

    // FSM state; named so checkers can bind to it directly.
    state_t state;
    state_t state_nxt;

    logic [IDW-1:0]   last_grant;
    logic [WIDTH-1:0] a_lat;
    logic [WIDTH-1:0] b_lat;
    logic [IDW-1:0]   id_lat;

    logic             win_found;
    logic [IDW-1:0]   win_id;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic             transfer;
    int               cand;

    // Round-robin search: first valid requester after last_grant, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last_grant) + k) % NUM_REQ;
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_id    = IDW'(cand);
            end
        end
    end

    // Operand mux for the current winner.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_id == IDW'(i)) begin
                sel_a = req_a[i*WIDTH +: WIDTH];
                sel_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    // Grant is one-hot to the winner, only in IDLE and never while in reset.
    always_comb begin
        req_ready = '0;
        if (rst_n && (state == IDLE) && win_found) begin
            req_ready[win_id] = 1'b1;
        end
    end

    assign transfer = |(req_valid & req_ready);
    assign busy     = (state != IDLE);

    // Next-state logic: IDLE -> ADD on a grant, ADD -> RESP, RESP -> IDLE on consume.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (transfer) state_nxt = ADD;
            ADD:     state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand capture, arbitration pointer and the registered adder/response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= IDW'(NUM_REQ - 1);
            a_lat      <= '0;
            b_lat      <= '0;
            id_lat     <= '0;
            rsp_valid  <= 1'b0;
            rsp_sum    <= '0;
            rsp_carry  <= 1'b0;
            rsp_id     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (transfer) begin
                        a_lat      <= sel_a;
                        b_lat      <= sel_b;
                        id_lat     <= win_id;
                        last_grant <= win_id;
                    end
                end
                ADD: begin
                    {rsp_carry, rsp_sum} <= {1'b0, a_lat} + {1'b0, b_lat};
                    rsp_id               <= id_lat;
                    rsp_valid            <= 1'b1;
                end
                RESP: begin
                    // Payload keeps its last value after the consume.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shared_adder_arbiter.sv
// tb_shared_adder_arbiter
// Directed bench for the shared round-robin adder. Inputs change and outputs
// are observed on the falling clock edge; the DUT acts on the rising edge.
module tb_shared_adder_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 8;
    localparam int IDW     = 2;

    logic                     clk;
    logic                     rst_n;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [WIDTH-1:0]         rsp_sum;
    logic                     rsp_carry;
    logic [IDW-1:0]           rsp_id;
    logic                     busy;

    int n_checks = 0;
    int n_fail   = 0;

    shared_adder_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_carry (rsp_carry),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    // Clock: 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present operands for one requester at the next falling edge, then drop
    // valid one cycle later (the requester is expected to win immediately).
    task automatic send(input int idx, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        @(negedge clk);
        req_a[idx*WIDTH +: WIDTH] = a;
        req_b[idx*WIDTH +: WIDTH] = b;
        req_valid[idx] = 1'b1;
        @(negedge clk);
        req_valid[idx] = 1'b0;
    endtask

    // Bounded wait for rsp_valid; an expired bound counts as a failure.
    task automatic wait_rsp(input string name);
        int n;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (rsp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_timeout: rsp_valid=%b required 1 within 20 cycles", name, rsp_valid);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        #1;
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready: got %b required 0000", req_ready); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b required 0", rsp_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
        n_checks++; if ({rsp_carry, rsp_sum, rsp_id} !== 11'h000) begin n_fail++; $display("FAIL reset_payload: got %h required 000", {rsp_carry, rsp_sum, rsp_id}); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL reset_first_grant: got %b required 0001", req_ready); end
        req_valid = '0;
    endtask

    task automatic test_single();
        @(negedge clk);
        req_a[7:0] = 8'h12;
        req_b[7:0] = 8'h34;
        req_valid[0] = 1'b1;
        rsp_ready = 1'b1;
        #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_grant: got %b required 0001", req_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_T: got %b required 0", busy); end
        @(negedge clk);
        req_valid[0] = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_T1: got %b required 1", busy); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_T1: got %b required 0", rsp_valid); end
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL single_ready_add: got %b required 0000", req_ready); end
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid_T2: got %b required 1", rsp_valid); end
        n_checks++; if (rsp_sum !== 8'h46) begin n_fail++; $display("FAIL single_sum: got %h required 46", rsp_sum); end
        n_checks++; if (rsp_carry !== 1'b0) begin n_fail++; $display("FAIL single_carry: got %b required 0", rsp_carry); end
        n_checks++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL single_id: got %0d required 0", rsp_id); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_T2: got %b required 1", busy); end
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_T3: got %b required 0", rsp_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_T3: got %b required 0", busy); end
        n_checks++; if (rsp_sum !== 8'h46) begin n_fail++; $display("FAIL single_sum_hold: got %h required 46", rsp_sum); end
    endtask

    task automatic test_overflow();
        logic [WIDTH-1:0] va [3];
        logic [WIDTH-1:0] vb [3];
        logic [WIDTH-1:0] vs [3];
        va = '{8'hFF, 8'h80, 8'hFF};
        vb = '{8'h01, 8'h80, 8'hFF};
        vs = '{8'h00, 8'h00, 8'hFE};
        rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            send(3, va[k], vb[k]);
            wait_rsp("overflow");
            n_checks++; if (rsp_sum !== vs[k]) begin n_fail++; $display("FAIL overflow_sum[%0d]: got %h required %h", k, rsp_sum, vs[k]); end
            n_checks++; if (rsp_carry !== 1'b1) begin n_fail++; $display("FAIL overflow_carry[%0d]: got %b required 1", k, rsp_carry); end
            n_checks++; if (rsp_id !== 2'd3) begin n_fail++; $display("FAIL overflow_id[%0d]: got %0d required 3", k, rsp_id); end
        end
    endtask

    task automatic test_round_robin();
        @(negedge clk);
        for (int i = 0; i < NUM_REQ; i++) begin
            req_a[i*WIDTH +: WIDTH] = WIDTH'(i);
            req_b[i*WIDTH +: WIDTH] = 8'h10;
        end
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            wait_rsp("round_robin");
            n_checks++; if (rsp_id !== IDW'(k % 4)) begin n_fail++; $display("FAIL rr_id[%0d]: got %0d required %0d", k, rsp_id, k % 4); end
            n_checks++; if (rsp_sum !== WIDTH'(8'h10 + k % 4)) begin n_fail++; $display("FAIL rr_sum[%0d]: got %h required %h", k, rsp_sum, 8'h10 + k % 4); end
            @(negedge clk);
        end
        req_valid = '0;
    endtask

    task automatic test_back_pressure();
        rsp_ready = 1'b0;
        send(2, 8'h21, 8'h42);
        wait_rsp("back_pressure");
        req_a[7:0] = 8'h05;
        req_b[7:0] = 8'h06;
        req_valid[0] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b required 1", c, rsp_valid); end
            n_checks++; if ({rsp_carry, rsp_sum} !== 9'h063) begin n_fail++; $display("FAIL bp_sum[%0d]: got %h required 063", c, {rsp_carry, rsp_sum}); end
            n_checks++; if (rsp_id !== 2'd2) begin n_fail++; $display("FAIL bp_id[%0d]: got %0d required 2", c, rsp_id); end
            n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_req_ready[%0d]: got %b required 0000", c, req_ready); end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_one_resp: got %b required 0", rsp_valid); end
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL bp_next_grant: got %b required 0001", req_ready); end
        @(negedge clk);
        req_valid[0] = 1'b0;
        wait_rsp("bp_follow");
        n_checks++; if (rsp_sum !== 8'h0B) begin n_fail++; $display("FAIL bp_follow_sum: got %h required 0b", rsp_sum); end
        n_checks++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL bp_follow_id: got %0d required 0", rsp_id); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        rsp_ready = 1'b0;
        send(1, 8'h03, 8'h04);
        wait_rsp("reset_mid");
        n_checks++; if (rsp_sum !== 8'h07) begin n_fail++; $display("FAIL rmid_sum: got %h required 07", rsp_sum); end
        req_a[23:16] = 8'h10;
        req_b[23:16] = 8'h20;
        req_valid[2] = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid_async: got %b required 0", rsp_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b required 0", busy); end
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rmid_req_ready: got %b required 0000", req_ready); end
        n_checks++; if (rsp_sum !== 8'h00) begin n_fail++; $display("FAIL rmid_sum_clear: got %h required 00", rsp_sum); end
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 4'b0101;
        rsp_ready = 1'b1;
        #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rmid_restart_grant: got %b required 0001", req_ready); end
        @(negedge clk);
        req_valid = '0;
        wait_rsp("rmid_follow");
        n_checks++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL rmid_follow_id: got %0d required 0", rsp_id); end
        n_checks++; if (rsp_sum !== 8'h0B) begin n_fail++; $display("FAIL rmid_follow_sum: got %h required 0b", rsp_sum); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_round_robin();
        test_back_pressure();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
